// File: rtl/axil_ram.sv
// AXI4-Lite responder over a word-organised RAM with byte-strobe writes.
// One outstanding write and one outstanding read, handled independently.
module axil_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int MW  = $clog2(DEPTH);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wstate_t wstate;
  rstate_t rstate;

  logic                  aw_held;
  logic                  w_held;
  logic [IW-1:0]         aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_data_eff;
  logic [STRB_WIDTH-1:0] w_strb_eff;
  logic                  w_ok;
  logic [IW-1:0]         r_idx;
  logic                  r_ok;

  assign s_awready = !rst && wstate == W_COLLECT && !aw_held;
  assign s_wready  = !rst && wstate == W_COLLECT && !w_held;
  assign s_arready = !rst && rstate == R_IDLE;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign ar_fire = s_arvalid && s_arready;

  // Beats may arrive on different cycles; use held copies once captured.
  assign w_idx      = aw_held ? aw_idx : s_awaddr[ADDR_WIDTH-1:LSB];
  assign w_data_eff = w_held ? w_data : s_wdata;
  assign w_strb_eff = w_held ? w_strb : s_wstrb;
  assign w_ok       = 32'(w_idx) < DEPTH;

  assign commit = !rst && wstate == W_COLLECT
               && (aw_held || aw_fire) && (w_held || w_fire);

  assign r_idx = s_araddr[ADDR_WIDTH-1:LSB];
  assign r_ok  = 32'(r_idx) < DEPTH;

  always_ff @(posedge clk) begin
    if (commit && w_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_eff[b]) begin
          mem[w_idx[MW-1:0]][b*8 +: 8] <= w_data_eff[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate   <= W_COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= OKAY;
    end else begin
      unique case (wstate)
        W_COLLECT: begin
          if (aw_fire) begin
            aw_held <= 1'b1;
            aw_idx  <= s_awaddr[ADDR_WIDTH-1:LSB];
          end
          if (w_fire) begin
            w_held <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
          end
          if (commit) begin
            wstate   <= W_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= w_ok ? OKAY : SLVERR;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wstate   <= W_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b0;
          end
        end
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  // Reads sample the array only at the AR handshake, so a same-edge
  // write to the same word is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      s_rvalid <= 1'b0;
      s_rresp  <= OKAY;
      s_rdata  <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_fire) begin
            rstate   <= R_RESP;
            s_rvalid <= 1'b1;
            s_rresp  <= r_ok ? OKAY : SLVERR;
            s_rdata  <= r_ok ? mem[r_idx[MW-1:0]] : '0;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            rstate   <= R_IDLE;
            s_rvalid <= 1'b0;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot,
                         s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};

endmodule

// File: tb/tb_axil_ram.sv
// Randomised bench for axil_ram against an array-based memory model.
// Covers latency, stalls, strobes, out-of-range, same-edge R/W and reset.
module tb_axil_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_awaddr;
  logic [2:0]  s_awprot;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [15:0] s_araddr;
  logic [2:0]  s_arprot;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [1024];

  always #5 clk = ~clk;

  axil_ram dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [15:0] a);
    return (a >> 2) < 1024;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [15:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_data(input logic [15:0] a);
    return in_range(a) ? mdl[a >> 2] : 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a >> 2][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Entered and left #1 after a rising edge.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, input int b_dly);
    logic [1:0] er;
    logic aw_done;
    er = exp_resp(a);
    aw_done = 1'b0;
    fork
      begin
        logic hs;
        hs = 1'b0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        s_awaddr = a;
        s_awvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
          @(negedge clk);
          hs = s_awready;
          @(posedge clk); #1;
        end
        s_awvalid = 1'b0;
        aw_done = 1'b1;
        check("aw_hs", {31'b0, hs}, 1);
      end
      begin
        logic hs;
        hs = 1'b0;
        for (int i = 0; i < w_dly; i++) begin
          @(negedge clk);
          if (aw_done) check("aw_wait_rdy", {31'b0, s_awready}, 0);
          @(posedge clk); #1;
        end
        s_wdata = d;
        s_wstrb = s;
        s_wvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
          @(negedge clk);
          hs = s_wready;
          @(posedge clk); #1;
        end
        s_wvalid = 1'b0;
        check("w_hs", {31'b0, hs}, 1);
      end
    join
    model_write(a, d, s);
    @(negedge clk);
    check("b_lat", {31'b0, s_bvalid}, 1);
    check("bresp", {30'b0, s_bresp}, {30'b0, er});
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b_hold_valid", {31'b0, s_bvalid}, 1);
      check("b_hold_resp", {30'b0, s_bresp}, {30'b0, er});
      check("b_hold_awrdy", {31'b0, s_awready}, 0);
      check("b_hold_wrdy", {31'b0, s_wready}, 0);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    check("b_done", {31'b0, s_bvalid}, 0);
    check("aw_rdy_back", {31'b0, s_awready}, 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [15:0] a, input int r_dly,
                          input logic [31:0] ed);
    logic [1:0] er;
    logic hs;
    er = exp_resp(a);
    hs = 1'b0;
    s_araddr = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    check("ar_hs", {31'b0, hs}, 1);
    @(negedge clk);
    check("r_lat", {31'b0, s_rvalid}, 1);
    check("rdata", s_rdata, ed);
    check("rresp", {30'b0, s_rresp}, {30'b0, er});
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("r_hold_valid", {31'b0, s_rvalid}, 1);
      check("r_hold_data", s_rdata, ed);
      check("r_hold_resp", {30'b0, s_rresp}, {30'b0, er});
      check("r_hold_arrdy", {31'b0, s_arready}, 0);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    @(negedge clk);
    check("r_done", {31'b0, s_rvalid}, 0);
    check("ar_rdy_back", {31'b0, s_arready}, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic rdy);
    check({tag, "_awrdy"}, {31'b0, s_awready}, {31'b0, rdy});
    check({tag, "_wrdy"}, {31'b0, s_wready}, {31'b0, rdy});
    check({tag, "_arrdy"}, {31'b0, s_arready}, {31'b0, rdy});
    check({tag, "_bvalid"}, {31'b0, s_bvalid}, 0);
    check({tag, "_rvalid"}, {31'b0, s_rvalid}, 0);
  endtask

  logic [15:0] pool [8];

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    pool = '{16'h0000, 16'h0004, 16'h0010, 16'h0080,
             16'h07f0, 16'h0ffc, 16'h1000, 16'hfff0};
    rst = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst", 1'b0);
    check("rst_bresp", {30'b0, s_bresp}, 0);
    check("rst_rresp", {30'b0, s_rresp}, 0);
    check("rst_rdata", s_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst", 1'b1);
    @(posedge clk); #1;

    axi_write(16'h0010, 32'hdeadbeef, 4'hf, 0, 0, 0);
    axi_read(16'h0010, 0, exp_data(16'h0010));
    check("rd_deadbeef", exp_data(16'h0010), 32'hdeadbeef);

    axi_write(16'h0010, 32'h000000aa, 4'b0001, 0, 3, 0);
    axi_read(16'h0010, 0, 32'hdeadbeaa);

    axi_write(16'h0010, 32'h12345678, 4'h0, 0, 0, 0);
    axi_read(16'h0012, 0, 32'hdeadbeaa);

    axi_write(16'h0000, 32'h0badf00d, 4'hf, 1, 0, 0);
    axi_write(16'h0ffc, 32'hcafef00d, 4'hf, 0, 0, 0);
    axi_read(16'h0ffc, 0, 32'hcafef00d);
    axi_write(16'h1000, 32'h55555555, 4'hf, 0, 0, 0);
    axi_read(16'h1000, 0, 32'h0);
    axi_read(16'h0ffc, 0, 32'hcafef00d);
    axi_read(16'h0000, 0, 32'h0badf00d);

    axi_write(16'h0044, 32'h01020304, 4'hf, 0, 0, 5);
    axi_read(16'h0044, 5, 32'h01020304);

    axi_write(16'h0080, 32'h11111111, 4'hf, 0, 0, 0);
    fork
      axi_write(16'h0080, 32'h22222222, 4'hf, 0, 0, 0);
      axi_read(16'h0080, 0, 32'h11111111);
    join
    axi_read(16'h0080, 0, 32'h22222222);

    // Leave a write response pending with AW held, plus a pending read.
    s_awaddr = 16'h0040; s_awvalid = 1'b1;
    s_wdata = 32'h7e7e7e7e; s_wstrb = 4'hf; s_wvalid = 1'b1;
    s_araddr = 16'h0080; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    model_write(16'h0040, 32'h7e7e7e7e, 4'hf);
    @(negedge clk);
    check("pre_rst_bvalid", {31'b0, s_bvalid}, 1);
    check("pre_rst_rvalid", {31'b0, s_rvalid}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("mid_rst", 1'b0);
    check("mid_rst_rdata", s_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_rst", 1'b1);
    @(posedge clk); #1;
    axi_read(16'h0040, 0, 32'h7e7e7e7e);
    axi_write(16'h0040, 32'h00ff0000, 4'b0100, 0, 0, 0);
    axi_read(16'h0040, 0, 32'h7eff7e7e);

    for (int i = 0; i < 8; i++)
      if (in_range(pool[i]))
        axi_write(pool[i], $urandom, 4'hf, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      a = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end else begin
        axi_read(a, $urandom_range(0, 2), exp_data(a));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_ram.md
Name: axil_ram

Overview:
- AXI4-Lite responder (slave) backed by a word-organised RAM with byte-strobe writes.
- Sits at the downstream (master-side) end of the unaligned-access splitter and answers its aligned single-word requests.
- Also serves as the generic on-chip scratch/data memory target.
- Handles one outstanding write and one outstanding read, independently.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width (bytes per word).
- DEPTH, 1024, number of words implemented.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_awaddr  in  ADDR_WIDTH  write byte address
- s_awprot  in  3  write protection (ignored)
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  STRB_WIDTH  write byte enables
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read byte address
- s_arprot  in  3  read protection (ignored)
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready

Behaviour:
- Clocking/reset: one clock domain `clk`; reset `rst` is synchronous, active-high.
- Reset values: while `rst` is high, all ready and valid outputs are 0, `s_bresp`/`s_rresp` are 0, and `s_rdata` is 0.
  - RAM contents are not cleared.
  - Asserting `rst` mid-transaction discards any held AW/W beats and drops a pending `bvalid`/`rvalid` without completing the handshake.
- Addressing: word index = `addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]`; low address bits are ignored (requests are aligned upstream).
  - Index ≥ DEPTH is out of range: the response is SLVERR (2'b10), no RAM write occurs, and `rdata` = 0.
  - In-range responses are OKAY (2'b00).
- Write FSM, two states:
  - W_COLLECT:
    - `s_awready` = !aw_held and `s_wready` = !w_held; the AW and W beats are accepted independently, in either order or the same cycle, and each is held in a register.
    - On the clock edge where both AW and W are available (held, or handshaking that cycle), the RAM write commits using the effective values.
    - Only the bytes with `wstrb` set are updated; `wstrb` = 0 writes nothing but still returns OKAY.
    - On that same edge the FSM moves to W_RESP, so `s_bvalid` = 1 from the next cycle.
    - Minimum latency: AW+W handshake in cycle N gives `bvalid` in cycle N+1.
  - W_RESP:
    - `s_awready` = `s_wready` = 0; `s_bvalid` = 1 and `s_bresp` stays stable until `s_bready`.
    - On the `bready` handshake the held flags clear and the FSM returns to W_COLLECT, so ready is high the following cycle.
- Read FSM, two states:
  - R_IDLE:
    - `s_arready` = 1.
    - An `arvalid` handshake registers the RAM word (or 0 with SLVERR) into `s_rdata`/`s_rresp` and moves to R_RESP; `s_rvalid` = 1 in the next cycle (latency 1).
  - R_RESP:
    - `s_arready` = 0; `s_rdata`/`s_rresp` are held stable until `s_rready`, then the FSM returns to R_IDLE.
- Channel independence: the read and write channels never stall each other.
  - If a write commit and a read handshake hit the same word on the same edge, the read returns the pre-write data.
- Inference: RAM is one synchronous-write / registered-read array that infers block RAM.
  - The read path reads the word at the AR handshake only; there is no combinational path from `araddr` to `rdata`.

Test Plan:
- Reset, then AW(0x0010) and W(0xDEADBEEF, strb 4'hF) in the same cycle → `bvalid` next cycle with `bresp` 00; AR 0x0010 → `rvalid` one cycle later with `rdata` 0xDEADBEEF, `rresp` 00.
- AW 0x0010 first, W (0x000000AA, strb 4'b0001) three cycles later → `awready` low while waiting; `bvalid` the cycle after the W handshake; readback = 0xDEADBEAA.
- AR or AW at byte address 4*DEPTH (0x1000) → resp 2'b10, `rdata` 0; a prior readback of word 0x3FF is unchanged.
- Hold `bready`/`rready` low for 5 cycles → `bvalid`/`rvalid`, `bresp`/`rresp` and `rdata` stay stable, and `awready`/`wready`/`arready` stay 0 for those cycles.
- Word 0x20 = 0x11111111; write 0x22222222 and read 0x20 handshaking on the same edge → the read returns 0x11111111; the next read returns 0x22222222.
- Assert `rst` for 1 cycle while `bvalid`=1 and an AW is held → after reset, `bvalid`=0 and `awready`=`wready`=`arready`=1; a fresh transaction completes normally.
